ram_dump_uart: RTL
==================

// Module: ram_dump_uart
// PURPOSE
//  Post-run memory dump stage. Sits beside the CPU data RAM; on the rising edge of perf_counter's
//  `finished`, reads RAM words 0..DUMP_WORDS-1 through a dedicated read port and transmits each
//  word as uppercase ASCII hex, MSB nibble first, followed by CR LF, over a UART TX line (8N1).
//  Lets the bench/host capture final RAM state without the VGA hex view.
// PARAMETERS
//  DATA_WIDTH          16        RAM word width; multiple of 4; NDIG = DATA_WIDTH/4 digits per word
//  RAM_REGISTER_COUNT  1024      RAM depth; rd_addr width AW = $clog2(RAM_REGISTER_COUNT)
//  DUMP_WORDS          1024      words dumped per run, 1..RAM_REGISTER_COUNT
//  CLKS_PER_BIT        434       CLK_50 cycles per UART bit (50 MHz / 115200), >= 2
// PORTS
//  CLK_50    in   1     single clock; all logic on posedge
//  resetN    in   1     synchronous active-low reset
//  finished  in   1     run-complete level from perf_counter
//  rd_addr   out  AW    RAM read address
//  rd_data   in   DW    RAM read data; valid exactly 1 cycle after rd_addr is presented (registered q)
//  uart_tx   out  1     serial output, idle high
//  busy      out  1     high from dump start until last LF stop bit completes
//  done      out  1     high after a dump completes, until next start or reset
// BEHAVIOUR
//  Reset (resetN=0 at posedge): uart_tx=1, busy=0, done=0, rd_addr=0, fin_q=0, FSM=IDLE, all
//   counters 0. Applies mid-frame/mid-byte: line returns high next edge, no partial byte completion.
//  Start: fin_q <= finished each cycle. start = finished & ~fin_q, honoured only in IDLE or DONE;
//   ignored while busy. Deassertion of finished mid-dump ignored; dump always runs to completion.
//  FSM: IDLE -> ADDR (busy=1, done=0, rd_addr=word_idx) -> WAIT (1 cycle, RAM latency) ->
//   LATCH (shift_reg <= rd_data, digit=0) -> DIGIT (load TX byte = ascii(shift_reg[DW-1:DW-4]),
//   wait TX idle, shift left 4, digit++ ; after NDIG digits) -> CR (0x0D) -> LF (0x0A) ->
//   if word_idx==DUMP_WORDS-1 then DONE (busy=0, done=1) else word_idx++, ADDR.
//  ASCII: nibble 0-9 -> 0x30+n; A-F -> 0x41+(n-10) (uppercase only).
//  TX engine: frame = start(0), 8 data bits LSB first, stop(1); each bit held CLKS_PER_BIT cycles
//   exactly; frame = 10*CLKS_PER_BIT cycles. Byte accepted on the cycle TX is idle; first start
//   bit appears on uart_tx the following cycle. Back-to-back bytes: no idle gap beyond 1 cycle.
//  Per-word time = (NDIG+2)*(10*CLKS_PER_BIT+1) cycles +3 (ADDR/WAIT/LATCH), tolerance 0 in sim.
//  word_idx width AW+1 so DUMP_WORDS==RAM_REGISTER_COUNT terminates without wrap; rd_addr never
//   exceeds DUMP_WORDS-1.
//  done and busy never high together. Simultaneous start and reset: reset wins.
//  rd_addr held stable from ADDR through LATCH; RAM writes during dump are not blocked (CPU halted).
// TESTING
//  CLKS_PER_BIT=4, DUMP_WORDS=2, RAM[0]=0x1A2F, RAM[1]=0x00F0; pulse finished -> decoded bytes
//   31 41 32 46 0D 0A 30 30 46 30 0D 0A, each bit exactly 4 cycles, then done=1, busy=0.
//  Hold finished high, then low, then high again after done -> second identical dump, done drops
//   for its duration; finished toggled while busy -> no restart, byte stream unchanged.
//  RAM[0]=0xFFFF, 0x0000, 0x9A0B across runs -> "FFFF","0000","9A0B" (ASCII boundary 9/A checked).
//  Assert resetN=0 mid-digit of word 0 -> next edge uart_tx=1, busy=0, done=0; after release no
//   output until a new finished rising edge.
//  DUMP_WORDS=RAM_REGISTER_COUNT=16 -> exactly 16 lines, rd_addr sequence 0..15, no wrap to 0.
//  Check rd_data sampled exactly 1 cycle after rd_addr: bench RAM model with 1-cycle latency,
//   distinct value per address -> no word shifted by one.

Source files
------------

// File: rtl/ram_dump_uart_if.sv
// RAM read-port bundle between the dump stage and the data RAM.
// master: drives rd_addr, receives rd_data (valid one cycle after rd_addr).
interface ram_dump_uart_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10
) ();
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;

    modport master (output rd_addr, input rd_data);
    modport slave  (input rd_addr, output rd_data);
endinterface

// File: rtl/ram_dump_uart.sv
// Post-run RAM dump: on a rising edge of finished, reads words 0..DUMP_WORDS-1
// and sends each as uppercase ASCII hex (MSB nibble first) + CR LF over 8N1 UART.
// Ports: CLK_50, resetN (sync, active low), finished, ram (read port master),
//        uart_tx (idle high), busy (dump in progress), done (dump finished).
module ram_dump_uart #(
    parameter int DATA_WIDTH         = 16,
    parameter int RAM_REGISTER_COUNT = 1024,
    parameter int DUMP_WORDS         = 1024,
    parameter int CLKS_PER_BIT       = 434
) (
    input  logic             CLK_50,
    input  logic             resetN,
    input  logic             finished,
    ram_dump_uart_if.master  ram,
    output logic             uart_tx,
    output logic             busy,
    output logic             done
);
    localparam int AW   = $clog2(RAM_REGISTER_COUNT);
    localparam int NDIG = DATA_WIDTH / 4;
    localparam int DGW  = $clog2(NDIG) + 1;
    localparam int CW   = $clog2(CLKS_PER_BIT);

    localparam logic [AW:0]     LAST_W = (AW+1)'(DUMP_WORDS - 1);
    localparam logic [DGW-1:0]  LAST_D = DGW'(NDIG - 1);
    localparam logic [CW-1:0]   LAST_C = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_WAIT, S_LATCH, S_DIGIT, S_CR, S_LF, S_FIN, S_DONE
    } state_t;

    state_t                state_q;
    logic                  fin_q;
    logic [AW:0]           word_q;
    logic [AW:0]           word_nxt;
    logic [AW-1:0]         rd_addr_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DGW-1:0]        digit_q;
    logic                  tx_busy_q;
    logic [8:0]            tx_sh_q;
    logic [3:0]            bit_q;
    logic [CW-1:0]         clk_q;
    logic                  tx_q;
    logic                  busy_q;
    logic                  done_q;

    logic                  start;
    logic                  tx_last;
    logic                  load;
    logic [7:0]            tx_byte;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    assign start    = finished & ~fin_q;
    assign word_nxt = word_q + (AW+1)'(1);
    // Last cycle of the stop bit: the FSM leaves FIN here so the next
    // word (or DONE) begins exactly as the line returns to idle.
    assign tx_last  = tx_busy_q && (bit_q == 4'd9) && (clk_q == LAST_C);

    always_comb begin
        load    = 1'b0;
        tx_byte = 8'h00;
        unique case (state_q)
            S_DIGIT: begin
                load    = ~tx_busy_q;
                tx_byte = hex_ascii(shift_q[DATA_WIDTH-1 -: 4]);
            end
            S_CR: begin
                load    = ~tx_busy_q;
                tx_byte = 8'h0D;
            end
            S_LF: begin
                load    = ~tx_busy_q;
                tx_byte = 8'h0A;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK_50) begin
        if (!resetN) begin
            state_q   <= S_IDLE;
            fin_q     <= 1'b0;
            word_q    <= '0;
            rd_addr_q <= '0;
            shift_q   <= '0;
            digit_q   <= '0;
            tx_busy_q <= 1'b0;
            tx_sh_q   <= '0;
            bit_q     <= '0;
            clk_q     <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            fin_q <= finished;

            // TX engine: tx_sh_q holds data bits then the stop bit.
            if (tx_busy_q) begin
                if (clk_q == LAST_C) begin
                    clk_q <= '0;
                    if (bit_q == 4'd9) begin
                        tx_busy_q <= 1'b0;
                        tx_q      <= 1'b1;
                    end else begin
                        tx_q    <= tx_sh_q[0];
                        tx_sh_q <= {1'b1, tx_sh_q[8:1]};
                        bit_q   <= bit_q + 4'd1;
                    end
                end else begin
                    clk_q <= clk_q + CW'(1);
                end
            end else if (load) begin
                tx_busy_q <= 1'b1;
                tx_q      <= 1'b0;
                tx_sh_q   <= {1'b1, tx_byte};
                bit_q     <= '0;
                clk_q     <= '0;
            end

            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q   <= S_ADDR;
                        word_q    <= '0;
                        rd_addr_q <= '0;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                    end
                end
                S_ADDR:  state_q <= S_WAIT;
                S_WAIT:  state_q <= S_LATCH;
                S_LATCH: begin
                    shift_q <= ram.rd_data;
                    digit_q <= '0;
                    state_q <= S_DIGIT;
                end
                S_DIGIT: begin
                    if (load) begin
                        shift_q <= {shift_q[DATA_WIDTH-5:0], 4'h0};
                        digit_q <= digit_q + DGW'(1);
                        if (digit_q == LAST_D) state_q <= S_CR;
                    end
                end
                S_CR: if (load) state_q <= S_LF;
                S_LF: if (load) state_q <= S_FIN;
                S_FIN: begin
                    if (tx_last) begin
                        if (word_q == LAST_W) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            word_q    <= word_nxt;
                            rd_addr_q <= word_nxt[AW-1:0];
                            state_q   <= S_ADDR;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ram.rd_addr = rd_addr_q;
    assign uart_tx     = tx_q;
    assign busy        = busy_q;
    assign done        = done_q;
endmodule
